// File: rtl/sing_io_responder.sv
// Half-duplex single-pin responder: receives a start/8-data/stop frame, waits a turnaround gap,
// then drives back the received byte XOR a mask on the same pin with mid-bit collision readback.
module sing_io_responder #(
    parameter int          BIT_CYCLES  = 8,
    parameter int          TURN_CYCLES = 4,
    parameter logic [7:0]  XOR_MASK    = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pin_i,
    output logic       pin_o,
    output logic       pin_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_busy,
    output logic       frame_err,
    output logic       collision,
    output logic [7:0] rx_count
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RX   = 3'd1;
    localparam logic [2:0] S_TURN = 3'd2;
    localparam logic [2:0] S_TX   = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;

    localparam int             CW        = 16;
    localparam logic [CW-1:0]  PH_LAST   = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0]  PH_MID    = CW'(BIT_CYCLES / 2);
    localparam logic [CW-1:0]  TURN_LAST = CW'(TURN_CYCLES - 1);
    localparam logic [3:0]     BIT_STOP  = 4'd9;

    logic [1:0]    sync_q;
    logic          s_in;
    logic [2:0]    state_q, state_d;
    logic          armed_q, armed_d;
    logic [CW-1:0] ph_q, ph_d;
    logic [3:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic [7:0]    rx_count_q, rx_count_d;
    logic          rx_valid_q, rx_valid_d;
    logic          frame_err_q, frame_err_d;

    logic [9:0]    tx_frame;
    logic          tx_bit;

    assign s_in     = sync_q[1];
    assign tx_frame = {1'b1, rx_data_q ^ XOR_MASK, 1'b0};
    assign tx_bit   = tx_frame[bit_q];

    // Released pad reads 1 through the pull-up, so pin_o idles high too.
    assign pin_oe    = (state_q == S_TX);
    assign pin_o     = pin_oe ? tx_bit : 1'b1;
    assign tx_busy   = (state_q == S_TURN) || (state_q == S_TX);
    assign collision = pin_oe && (ph_q == PH_MID) && (s_in != tx_bit);

    assign rx_data   = rx_data_q;
    assign rx_count  = rx_count_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;

    always_comb begin
        state_d     = state_q;
        armed_d     = armed_q;
        ph_d        = ph_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_count_d  = rx_count_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                ph_d  = '0;
                bit_d = '0;
                if (!armed_q) begin
                    if (s_in) armed_d = 1'b1;
                end else if (!s_in) begin
                    state_d = S_RX;
                end
            end
            S_RX: begin
                if (ph_q == PH_LAST) begin
                    ph_d  = '0;
                    bit_d = bit_q + 4'd1;
                end else begin
                    ph_d = ph_q + CW'(1);
                end
                if (ph_q == PH_MID) begin
                    if (bit_q == 4'd0) begin
                        if (s_in) state_d = S_IDLE;
                    end else if (bit_q == BIT_STOP) begin
                        ph_d = '0;
                        if (s_in) begin
                            rx_data_d  = shift_q;
                            rx_valid_d = 1'b1;
                            rx_count_d = rx_count_q + 8'd1;
                            state_d    = S_TURN;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = S_ERR;
                        end
                    end else begin
                        shift_d = {s_in, shift_q[7:1]};
                    end
                end
            end
            S_TURN: begin
                if (ph_q == TURN_LAST) begin
                    ph_d    = '0;
                    bit_d   = '0;
                    state_d = S_TX;
                end else begin
                    ph_d = ph_q + CW'(1);
                end
            end
            S_TX: begin
                if (collision) begin
                    ph_d    = '0;
                    state_d = S_ERR;
                end else if (ph_q == PH_LAST) begin
                    ph_d = '0;
                    if (bit_q == BIT_STOP) begin
                        state_d = S_IDLE;
                        armed_d = 1'b1;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    ph_d = ph_q + CW'(1);
                end
            end
            S_ERR: begin
                // Wait for a full bit time of continuous idle-high before re-arming.
                if (!s_in) begin
                    ph_d = '0;
                end else if (ph_q == PH_LAST) begin
                    ph_d    = '0;
                    state_d = S_IDLE;
                    armed_d = 1'b1;
                end else begin
                    ph_d = ph_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q      <= 2'b11;
            state_q     <= S_IDLE;
            armed_q     <= 1'b0;
            ph_q        <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_count_q  <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], pin_i};
            state_q     <= state_d;
            armed_q     <= armed_d;
            ph_q        <= ph_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_count_q  <= rx_count_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

endmodule
